// File: rtl/operand_capture.sv
// operand_capture: keypad front end that turns strobed BCD digits (MSD first) into
// NOPS binary magnitudes of NDIG digits each, with a per-operand sign and valid/ack.
// Optional feature macro: ENTRY_TIMEOUT_EN adds an idle timeout that discards a
// partial entry after TIMEOUT_CYC cycles without a new digit.
module operand_capture #(
   parameter int NDIG        = 2,
   parameter int NOPS        = 2,
   parameter int OUT_W       = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dat_ready,
   input  logic [3:0]            dato,
   input  logic                  signo,
   input  logic                  clear,
   input  logic                  ack,
   output logic [NOPS*OUT_W-1:0] numeros,
   output logic [NOPS-1:0]       signos,
   output logic                  valid,
   output logic                  busy,
   output logic                  err
);

   localparam int OPW = (NOPS > 1) ? $clog2(NOPS) : 1;
   localparam int DGW = (NDIG > 1) ? $clog2(NDIG) : 1;

   if (NDIG < 1 || NOPS < 1) begin : g_bad_shape
      $error("operand_capture: NDIG and NOPS must both be at least 1");
   end
   if ((OUT_W < 31) && ((2 ** OUT_W) < (10 ** NDIG))) begin : g_bad_width
      $error("operand_capture: OUT_W too narrow for NDIG decimal digits");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("operand_capture: TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic {CAPTURE, DONE} state_t;

   state_t           state, state_n;
   logic [OUT_W-1:0] acc   [NOPS];
   logic [OUT_W-1:0] acc_n [NOPS];
   logic [NOPS-1:0]  sgn_n;
   logic [OPW-1:0]   op_idx, op_n;
   logic [DGW-1:0]   dig_idx, dig_n;
   logic             prev_rdy;
   logic             valid_n, busy_n, err_n;
   logic             accept, wipe, tmo_hit;

   // acc*10 + digit carried at OUT_W+4 bits; the width check rules out overflow
   function automatic logic [OUT_W-1:0] bcd_mac(input logic [OUT_W-1:0] a,
                                                input logic [3:0]       d);
      return OUT_W'({4'b0000, a} * (OUT_W+4)'(10) + {{OUT_W{1'b0}}, d});
   endfunction

   for (genvar k = 0; k < NOPS; k++) begin : g_out
      assign numeros[k*OUT_W +: OUT_W] = acc[k];
   end

   assign accept = dat_ready & ~prev_rdy;
   assign wipe   = clear | tmo_hit;

`ifdef ENTRY_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] idle_cnt;

   assign tmo_hit = busy && (idle_cnt == CW'(TIMEOUT_CYC - 1));

   // Idle counter: runs only while a partial entry waits for its next digit
   always_ff @(posedge clk) begin
      if (rst || clear || tmo_hit || accept || !busy) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state logic: discard > ack > digit accept
   always_comb begin
      state_n = state;
      sgn_n   = signos;
      op_n    = op_idx;
      dig_n   = dig_idx;
      err_n   = 1'b0;
      for (int k = 0; k < NOPS; k++) acc_n[k] = acc[k];

      if (wipe) begin
         state_n = CAPTURE;
         sgn_n   = '0;
         op_n    = '0;
         dig_n   = '0;
         for (int k = 0; k < NOPS; k++) acc_n[k] = '0;
         err_n   = tmo_hit & ~clear;
      end else begin
         case (state)
            CAPTURE: begin
               if (accept) begin
                  if (dato > 4'd9) begin
                     err_n = 1'b1;
                  end else begin
                     acc_n[op_idx] = bcd_mac(acc[op_idx], dato);
                     if (dig_idx == '0) sgn_n[op_idx] = signo;
                     if (dig_idx == DGW'(NDIG - 1)) begin
                        dig_n = '0;
                        if (op_idx == OPW'(NOPS - 1)) begin
                           op_n    = '0;
                           state_n = DONE;
                        end else begin
                           op_n = op_idx + 1'b1;
                        end
                     end else begin
                        dig_n = dig_idx + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (ack) begin
                  state_n = CAPTURE;
                  sgn_n   = '0;
                  op_n    = '0;
                  dig_n   = '0;
                  for (int k = 0; k < NOPS; k++) acc_n[k] = '0;
               end
            end
            default: state_n = CAPTURE;
         endcase
      end

      valid_n = (state_n == DONE);
      busy_n  = ((op_n != '0) || (dig_n != '0)) && !valid_n;
   end

   // State, operand and status registers; prev_rdy tracks dat_ready every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CAPTURE;
         for (int k = 0; k < NOPS; k++) acc[k] <= '0;
         signos   <= '0;
         op_idx   <= '0;
         dig_idx  <= '0;
         prev_rdy <= 1'b0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         for (int k = 0; k < NOPS; k++) acc[k] <= acc_n[k];
         signos   <= sgn_n;
         op_idx   <= op_n;
         dig_idx  <= dig_n;
         prev_rdy <= dat_ready;
         valid    <= valid_n;
         busy     <= busy_n;
         err      <= err_n;
      end
   end

endmodule

// File: tb/tb_operand_capture.sv
// Testbench for operand_capture: table-driven directed vectors, hand-written
// multi-cycle sequences, then randomized traffic against a digit-queue model.
module tb_operand_capture;

   localparam int NDIG  = 2;
   localparam int NOPS  = 2;
   localparam int OUT_W = 8;
   localparam int TMO   = 16;

   logic                  clk = 1'b0;
   logic                  rst, dat_ready, signo, clear, ack;
   logic [3:0]            dato;
   logic [NOPS*OUT_W-1:0] numeros;
   logic [NOPS-1:0]       signos;
   logic                  valid, busy, err;

   int checks = 0;
   int errors = 0;

   operand_capture #(
      .NDIG(NDIG), .NOPS(NOPS), .OUT_W(OUT_W), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst(rst), .dat_ready(dat_ready), .dato(dato), .signo(signo),
      .clear(clear), .ack(ack), .numeros(numeros), .signos(signos),
      .valid(valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Reference model: the entry is the list of accepted digits
   int              q[$];
   logic [NOPS-1:0] m_sg;
   bit              m_valid, m_err, m_prev;
   int              m_idle;

   function automatic logic [NOPS*OUT_W-1:0] m_num();
      logic [NOPS*OUT_W-1:0] r;
      int v;
      r = '0;
      for (int k = 0; k < NOPS; k++) begin
         v = 0;
         for (int i = 0; i < NDIG; i++)
            if (k*NDIG + i < q.size()) v = v*10 + q[k*NDIG + i];
         r[k*OUT_W +: OUT_W] = OUT_W'(v);
      end
      return r;
   endfunction

   task automatic model_step(input bit r, input bit dr, input logic [3:0] d,
                             input bit s, input bit c, input bit a);
      bit acc_e, busy_prev, tmo;
      if (r) begin
         q.delete(); m_sg = '0; m_valid = 0; m_err = 0; m_prev = 0; m_idle = 0;
         return;
      end
      acc_e     = dr && !m_prev;
      m_prev    = dr;
      busy_prev = (q.size() > 0) && !m_valid;
      tmo       = 0;
      m_err     = 0;
`ifdef ENTRY_TIMEOUT_EN
      if (busy_prev && !c) begin
         if (m_idle == TMO - 1) tmo = 1;
         m_idle = acc_e ? 0 : m_idle + 1;
      end else begin
         m_idle = 0;
      end
`endif
      if (c || tmo) begin
         q.delete(); m_sg = '0; m_valid = 0; m_idle = 0; m_err = tmo;
      end else if (m_valid) begin
         if (a) begin q.delete(); m_sg = '0; m_valid = 0; end
      end else if (acc_e) begin
         if (d > 9) m_err = 1;
         else begin
            if (q.size() % NDIG == 0) m_sg[q.size()/NDIG] = s;
            q.push_back(int'(d));
            if (q.size() == NDIG*NOPS) m_valid = 1;
         end
      end
   endtask

   task automatic step(input logic r, input logic dr, input logic [3:0] d,
                       input logic s, input logic c, input logic a);
      rst = r; dat_ready = dr; dato = d; signo = s; clear = c; ack = a;
      @(posedge clk);
      #1;
      model_step(r, dr, d, s, c, a);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] n, input logic [1:0] sg,
                          input logic v, input logic b, input logic e);
      chk({tag, " numeros"}, 32'(numeros), 32'(n));
      chk({tag, " signos"},  32'(signos),  32'(sg));
      chk({tag, " valid"},   32'(valid),   32'(v));
      chk({tag, " busy"},    32'(busy),    32'(b));
      chk({tag, " err"},     32'(err),     32'(e));
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " numeros"}, 32'(numeros), 32'(m_num()));
      chk({tag, " signos"},  32'(signos),  32'(m_sg));
      chk({tag, " valid"},   32'(valid),   32'(m_valid));
      chk({tag, " busy"},    32'(busy),    32'((q.size() > 0) && !m_valid));
      chk({tag, " err"},     32'(err),     32'(m_err));
   endtask

   typedef struct packed {
      logic        dr;
      logic [3:0]  d;
      logic        s;
      logic        c;
      logic        a;
      logic [15:0] num;
      logic [1:0]  sg;
      logic        v;
      logic        b;
      logic        e;
   } vec_t;

   vec_t tbl[16];
   int   err_seen;

   initial begin
      // dr, d, s, c, a | numeros, signos, valid, busy, err
      tbl[0]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 16'h0009, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0009, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 16'h0063, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0063, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 16'h0163, 2'b10, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0163, 2'b10, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 16'h0F63, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0F63, 2'b10, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 4'hC,  1'b0, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0002, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 16'h001B, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h001B, 2'b00, 1'b0, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; dat_ready = 1'b0; dato = 4'd0; signo = 1'b0; clear = 1'b0; ack = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      chk_all("reset", 16'h0000, 2'b00, 0, 0, 0);

      // Entry 99,+15 then ack; bad digit rejected mid-operand; clear
      for (int i = 0; i < 16; i++) begin
         step(0, tbl[i].dr, tbl[i].d, tbl[i].s, tbl[i].c, tbl[i].a);
         chk_all($sformatf("vec%0d", i), tbl[i].num, tbl[i].sg, tbl[i].v, tbl[i].b, tbl[i].e);
      end

      // Level held five cycles yields one digit
      for (int i = 0; i < 5; i++) step(0, 1, 3, 0, 0, 0);
      chk_all("hold5", 16'h0003, 2'b00, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 4, 0, 0, 0);
      chk_all("hold5 next", 16'h0022, 2'b00, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);

      // Clear after three digits, then a fresh 0,4,2,0 entry
      step(0, 1, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      chk_all("three digits", 16'h030C, 2'b00, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      chk_all("clear", 16'h0000, 2'b00, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 1, 4, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk_all("entry 4,20", 16'h1404, 2'b00, 1, 0, 0);

      // Digit ignored while DONE, then ack
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 8, 0, 0, 0);
      chk_all("done digit", 16'h1404, 2'b00, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk_all("done ack", 16'h0000, 2'b00, 0, 0, 0);

      // ack without valid is ignored; digit coinciding with clear is dropped
      step(0, 1, 5, 1, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk_all("early ack", 16'h0005, 2'b01, 0, 1, 0);
      step(0, 1, 9, 0, 1, 0);
      chk_all("clear+digit", 16'h0000, 2'b00, 0, 0, 0);
      step(0, 1, 9, 0, 0, 0);
      chk_all("no edge after clear", 16'h0000, 2'b00, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // dat_ready high across reset release counts as an edge
      step(1, 1, 6, 0, 0, 0);
      chk_all("in reset", 16'h0000, 2'b00, 0, 0, 0);
      step(0, 1, 6, 0, 0, 0);
      chk_all("edge at release", 16'h0006, 2'b00, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);

      // Idle behaviour after a single digit
      step(0, 1, 7, 0, 0, 0);
      err_seen = 0;
`ifdef ENTRY_TIMEOUT_EN
      for (int i = 0; i < TMO - 1; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (err) err_seen++;
      end
      chk("early timeout", 32'(err_seen), 32'd0);
      chk_all("pre timeout", 16'h0007, 2'b00, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk_all("timeout", 16'h0000, 2'b00, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk_all("after timeout", 16'h0000, 2'b00, 0, 0, 0);
`else
      for (int i = 0; i < 100; i++) begin
         step(0, 0, 0, 0, 0, 0);
         if (err) err_seen++;
      end
      chk("idle err pulses", 32'(err_seen), 32'd0);
      chk_all("idle 100", 16'h0007, 2'b00, 0, 1, 0);
`endif

      // Randomized traffic against the model
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         logic       r, dr, s, c, a;
         logic [3:0] d;
         r  = ($urandom_range(0, 299) == 0);
         dr = 1'($urandom_range(0, 1));
         d  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         s  = 1'($urandom_range(0, 1));
         c  = ($urandom_range(0, 79) == 0);
         a  = ($urandom_range(0, 3) == 0);
         step(r, dr, d, s, c, a);
         chk_model($sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
